// File: rtl/fibonachi_checker.sv
// Fibonacci stream checker: seeds from the first two terms,
// then compares each later term against its own running sum.
module fibonachi_checker #(
  parameter int WIDTH = 4,
  parameter int TERMS = 10,
  parameter int CNT_W = $clog2(TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] term_cnt,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic             wrapped,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    SEED0,
    SEED1,
    CHECK,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TERMS);
  localparam logic [CNT_W-1:0] T_END = CNT_W'(TERMS - 1);

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] sum;
  logic             bad;
  logic             last;
  logic [CNT_W-1:0] err_nxt;

  // Next term from our own history, never from the stream.
  always_comb begin
    s       = {1'b0, a} + {1'b0, b};
    sum     = s[WIDTH-1:0];
    bad     = (in_data != sum);
    last    = (term_cnt == T_END);
    err_nxt = err_cnt;
    if (bad && (err_cnt != T_MAX))
      err_nxt = err_cnt + ONE;
  end

  // Seed capture, checking and done/pass bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SEED0;
      a        <= '0;
      b        <= '0;
      expected <= '0;
      term_cnt <= '0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
      wrapped  <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (in_valid) begin
        unique case (state)
          SEED0: begin
            a        <= in_data;
            term_cnt <= ONE;
            state    <= SEED1;
          end
          SEED1: begin
            b        <= in_data;
            term_cnt <= TWO;
            expected <= a + in_data;
            state    <= CHECK;
          end
          CHECK: begin
            mismatch <= bad;
            err_cnt  <= err_nxt;
            wrapped  <= wrapped | s[WIDTH];
            a        <= b;
            b        <= sum;
            expected <= b + sum;
            term_cnt <= term_cnt + ONE;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end
          end
          DONE: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
